// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default payload width.
package uart_pkg;

  // Default number of payload bits carried by one frame.
  localparam int UART_DATA_WIDTH = 8;

  // Frame-level FSM states shared by the UART receiver and transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } uart_state_e;

  // Width of a bit index covering 0..w-1, never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; all stages reset to
// the idle-high level so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic rx_async,
  output logic rx_sync
);

  logic [STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage captures the raw line.
        always_ff @(posedge CLK or negedge RESET) begin
          if (!RESET) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= rx_async;
        end
      end else begin : g_chain
        // Later stages resolve metastability of the previous stage.
        always_ff @(posedge CLK or negedge RESET) begin
          if (!RESET) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: one bit per clock, start(0) + DATA_WIDTH bits MSB first + stop(1).
// Holds one frame for a valid/ready consumer, flags dropped frames (sticky overrun)
// and bad stop bits (one-cycle framing_error).
// Optional build macro UART_RECEIVER_SYNC_EN inserts a two-flop rx synchronizer,
// adding two cycles to every latency.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int IDX_W = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_reg, state_next;
  logic [IDX_W-1:0]      index_reg, index_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  framing_error_reg;
  logic                  overrun_reg;

  logic rx_fsm;
  logic deliver;
  logic frame_bad;
  logic accept;

`ifdef UART_RECEIVER_SYNC_EN
  uart_rx_sync #(
    .STAGES(2)
  ) u_rx_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .rx_async (rx),
    .rx_sync  (rx_fsm)
  );
`else
  assign rx_fsm = rx;
`endif

  // Frame FSM state, bit index and shift register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      index_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: sample one bit per cycle, flag delivery or a bad stop bit.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    shift_next = shift_reg;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_fsm) begin
          state_next = DATA;
          index_next = IDX_TOP;
        end
      end
      DATA: begin
        shift_next[index_reg] = rx_fsm;
        if (index_reg == '0) begin
          state_next = STOP;
        end else begin
          index_next = index_reg - 1'b1;
        end
      end
      STOP: begin
        if (rx_fsm) begin
          // Back to IDLE immediately so a start bit on the next cycle is caught.
          state_next = IDLE;
          deliver    = 1'b1;
        end else begin
          // Line held low through the stop slot: drop the frame and wait for idle.
          state_next = BREAK;
          frame_bad  = 1'b1;
        end
      end
      BREAK: begin
        if (rx_fsm) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = valid_reg && ready;

  // Output holding register with valid/ready handshake and error flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_reg          <= '0;
      valid_reg         <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      framing_error_reg <= frame_bad;
      // A frame can land when the slot is empty or being emptied on this edge.
      if (deliver && (!valid_reg || ready)) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
      // Consumption clears the sticky flag; a frame arriving at a full,
      // unconsumed slot sets it.
      if (accept) begin
        overrun_reg <= 1'b0;
      end else if (deliver && valid_reg) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign data          = data_reg;
  assign valid         = valid_reg;
  assign framing_error = framing_error_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed, table-driven bench for uart_receiver plus hand-written corner sequences.
module tb_uart_receiver;

  localparam int DW = 8;
`ifdef UART_RECEIVER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          CLK   = 1'b0;
  logic          RESET = 1'b0;
  logic          rx    = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          framing_error;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_receiver #(.DATA_WIDTH(DW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       rdy;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick();
  endtask

  // Bit i of a frame on the line: 0 start, 1..8 data MSB first, 9 stop, then idle.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return b[DW-i];
    if (i == DW + 1) return stop;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < DW + 2 + LAT; i++) drive_bit(frame_bit(b, stop, i));
  endtask

  // Frame with exact latency check: valid low one cycle before, high with data after.
  task automatic send_timed(input logic [7:0] b, input string name);
    for (int i = 0; i < DW + 2 + LAT; i++) begin
      drive_bit(frame_bit(b, 1'b1, i));
      if (i == DW + LAT) check({name, "_valid_early"}, valid, 1'b0);
    end
    check({name, "_valid"}, valid, 1'b1);
    check({name, "_data"}, data, b);
    check({name, "_fe"}, framing_error, 1'b0);
    check({name, "_ovr"}, overrun, 1'b0);
    $display("seq %s: data=0x%02h valid=%0b fe=%0b ovr=%0b", name, data, valid, framing_error, overrun);
  endtask

  task automatic drain();
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3 + LAT) tick();
    ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};

    // Reset state.
    repeat (3) tick();
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    $display("seq reset: data=0x%02h valid=%0b fe=%0b ovr=%0b", data, valid, framing_error, overrun);
    RESET = 1'b1;
    repeat (2) tick();

    // Frame 0xA5 with ready high, exact delivery latency.
    ready = 1'b1;
    send_timed(8'hA5, "a5_latency");
    drain();

    // Table of single frames.
    for (int v = 0; v < 7; v++) begin
      ready = vecs[v].rdy;
      send_frame(vecs[v].din, vecs[v].stop);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      check($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_fe", v), framing_error, vecs[v].exp_fe);
      check($sformatf("vec%0d_ovr", v), overrun, vecs[v].exp_ovr);
      $display("vec %0d: din=0x%02h stop=%0b rdy=%0b -> data=0x%02h valid=%0b fe=%0b ovr=%0b",
               v, vecs[v].din, vecs[v].stop, vecs[v].rdy, data, valid, framing_error, overrun);
      drive_bit(1'b1);
      check($sformatf("vec%0d_valid_next", v), valid, vecs[v].exp_valid & ~vecs[v].rdy);
      check($sformatf("vec%0d_fe_next", v), framing_error, 1'b0);
      drain();
    end

    // Back-to-back 0x3C, 0xC3 with ready low: second dropped, overrun set.
    ready = 1'b0;
    for (int i = 0; i < DW + 2; i++) drive_bit(frame_bit(8'h3C, 1'b1, i));
    send_frame(8'hC3, 1'b1);
    check("b2b_data", data, 8'h3C);
    check("b2b_valid", valid, 1'b1);
    check("b2b_ovr", overrun, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("b2b_pop_valid", valid, 1'b0);
    check("b2b_pop_ovr", overrun, 1'b0);
    check("b2b_pop_data", data, 8'h3C);
    $display("seq back_to_back: data=0x%02h valid=%0b ovr=%0b", data, valid, overrun);
    drain();

    // Framing error on 0x81, line low 5 more cycles, then idle; ready low so a
    // spurious frame would remain visible.
    ready = 1'b0;
    for (int i = 0; i < DW + 2 + 5 + 12; i++) begin
      drive_bit((i <= DW) ? frame_bit(8'h81, 1'b0, i) : (i < DW + 2 + 5 ? 1'b0 : 1'b1));
      if (i == DW + 1 + LAT) begin
        check("brk_fe_pulse", framing_error, 1'b1);
        check("brk_valid", valid, 1'b0);
      end
      if (i == DW + 2 + LAT) check("brk_fe_clear", framing_error, 1'b0);
    end
    check("brk_no_frame", valid, 1'b0);
    check("brk_data_kept", data, 8'h3C);
    send_frame(8'h5A, 1'b1);
    check("brk_next_data", data, 8'h5A);
    check("brk_next_valid", valid, 1'b1);
    $display("seq framing_break: data=0x%02h valid=%0b fe=%0b", data, valid, framing_error);
    drain();

    // Same-edge consume and deliver: 0x11 held, ready on 0x22 delivery edge.
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    check("same_first_data", data, 8'h11);
    check("same_first_valid", valid, 1'b1);
    for (int i = 0; i < DW + 2 + LAT; i++) begin
      if (i == DW + 1 + LAT) ready = 1'b1;
      drive_bit(frame_bit(8'h22, 1'b1, i));
      ready = 1'b0;
    end
    check("same_data", data, 8'h22);
    check("same_valid", valid, 1'b1);
    check("same_ovr", overrun, 1'b0);
    tick();
    check("same_hold_valid", valid, 1'b1);
    $display("seq same_edge: data=0x%02h valid=%0b ovr=%0b", data, valid, overrun);
    drain();

    // Reset mid-frame of 0xFF with a full slot and overrun pending.
    ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    check("mid_pre_ovr", overrun, 1'b1);
    for (int i = 0; i < 5; i++) drive_bit(frame_bit(8'hFF, 1'b1, i));
    #2;
    RESET = 1'b0;
    #1;
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_fe", framing_error, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    rx = 1'b1;
    repeat (3) tick();
    RESET = 1'b1;
    for (int i = 5; i < DW + 2 + 4; i++) drive_bit(frame_bit(8'hFF, 1'b1, i));
    check("mid_idle_valid", valid, 1'b0);
    check("mid_idle_data", data, 8'h00);
    $display("seq reset_mid_frame: data=0x%02h valid=%0b ovr=%0b", data, valid, overrun);
    ready = 1'b1;
    send_timed(8'h5A, "post_reset");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL provide parameter: DATA_WIDTH, 8, payload bits per frame.
REQ-002 SHALL provide port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: RESET  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: rx  input  1  serial line; idle high.
REQ-005 SHALL provide port: data  output  DATA_WIDTH  received byte; registered.
REQ-006 SHALL provide port: valid  output  1  data holds an unconsumed frame.
REQ-007 SHALL provide port: ready  input  1  consumer accepts data when valid && ready at a rising edge.
REQ-008 SHALL provide port: framing_error  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL provide port: overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-010 SHALL accept frames of one bit per CLK cycle: start (0), DATA_WIDTH data bits MSB first, stop (1); frame length DATA_WIDTH+2 cycles.
REQ-011 SHALL implement states IDLE, DATA, STOP and BREAK.
REQ-012 IDLE: rx==0 sampled -> DATA, bit index = DATA_WIDTH-1; rx==1 -> remain IDLE.
REQ-013 DATA: SHALL store the sampled rx into shift bit [index] and decrement index; at index==0 -> STOP.
REQ-014 STOP with rx==1: SHALL go to IDLE and deliver the frame per REQ-016..018; a start bit on the very next cycle (back-to-back frames) SHALL be received.
REQ-015 STOP with rx==0: SHALL discard the frame, pulse framing_error for exactly one cycle, and enter BREAK; BREAK -> IDLE only after rx==1 is sampled.
REQ-016 Delivery, valid low: data loaded and valid asserted in the cycle after the stop-bit edge (latency: start-bit edge + DATA_WIDTH+2 cycles).
REQ-017 valid SHALL stay high with data stable until the valid && ready edge; valid then deasserts unless REQ-018 applies.
REQ-018 Delivery on the same edge as valid && ready: new frame loaded, valid stays high, no overrun.
REQ-019 Delivery while valid high and ready low: new frame discarded, held data unchanged, overrun set.
REQ-020 overrun SHALL clear on the next valid && ready edge.
REQ-021 rx SHALL be ignored outside the sampling rules above; no glitch filtering in the base configuration.

Reset
REQ-022 RESET low SHALL immediately force state IDLE, index 0, data 0, valid 0, framing_error 0, overrun 0, shift register 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL begin only at the next start bit sampled in IDLE.

Configuration
REQ-024 Macro UART_RECEIVER_SYNC_EN defined: rx SHALL pass through a two-flop synchronizer (reset value 1) before the FSM, adding exactly 2 cycles to all latencies.
REQ-025 Macro UART_RECEIVER_SYNC_EN undefined: rx SHALL feed the FSM directly with the latencies of REQ-016.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state typedef (IDLE, DATA, STOP, BREAK) and the default DATA_WIDTH constant, shared with the transmitter.
REQ-027 The synchronizer SHALL be a sub-module named uart_rx_sync, instantiated only under UART_RECEIVER_SYNC_EN.

Verification
REQ-028 Frame 0xA5 (rx: 0,1,0,1,0,0,1,0,1,1), ready=1 -> valid high one cycle after stop edge with data=0xA5; no error flags.
REQ-029 Back-to-back frames 0x3C then 0xC3, ready held low until the second completes -> data=0x3C retained, overrun=1; ready pulse -> valid low, overrun=0.
REQ-030 Frame 0x81 with stop bit 0, rx held low 5 more cycles, then 1 -> framing_error one-cycle pulse, valid stays 0, no frame started until rx returns high.
REQ-031 Same-edge test: valid high with 0x11, ready asserted on the stop-delivery edge of 0x22 -> data=0x22, valid stays high, overrun=0.
REQ-032 RESET low after 4th data bit of 0xFF, released with rx=1 -> all outputs 0; next frame 0x5A received correctly; repeat with UART_RECEIVER_SYNC_EN -> latency +2 cycles.
